// File: rtl/float_convert.sv
// float_convert
// Converts an IEEE-style binary floating-point operand from one format
// {sign, IN_EW-bit exponent, IN_MW-bit fraction} to another format
// {sign, OUT_EW-bit exponent, OUT_MW-bit fraction}. The same logic covers
// widening, narrowing and equal-width conversion, including subnormals,
// infinities and NaNs. Narrowing rounds to nearest, ties to even.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   rst           asynchronous, active-low reset
//   input_a       source operand {sign, exp, frac}
//   input_a_stb   source operand valid
//   input_a_ack   block ready to take an operand (registered)
//   output_z      converted result
//   output_z_stb  result valid, held until output_z_ack is seen
//   output_z_ack  consumer accepts the result
//   output_flags  {invalid, overflow, underflow, inexact}, valid with output_z_stb
module float_convert #(
    parameter int IN_EW  = 8,
    parameter int IN_MW  = 23,
    parameter int OUT_EW = 11,
    parameter int OUT_MW = 52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_EW+IN_MW:0]     input_a,
    input  logic                     input_a_stb,
    output logic                     input_a_ack,
    output logic [OUT_EW+OUT_MW:0]   output_z,
    output logic                     output_z_stb,
    input  logic                     output_z_ack,
    output logic [3:0]               output_flags
);

    localparam int MAXEW    = (IN_EW > OUT_EW) ? IN_EW : OUT_EW;
    localparam int MAXMW    = (IN_MW > OUT_MW) ? IN_MW : OUT_MW;
    localparam int IW       = MAXEW + 2;
    // Working mantissa: hidden bit, widest fraction, then guard and round
    // positions, so the destination guard bit always lives in the register.
    localparam int LW       = MAXMW + 3;
    localparam int PADW     = LW - 1 - IN_MW;
    localparam int LOWW     = LW - 2 - OUT_MW;
    localparam int SW       = OUT_MW + 2;
    localparam int IN_BIAS  = (1 << (IN_EW - 1)) - 1;
    localparam int OUT_BIAS = (1 << (OUT_EW - 1)) - 1;
    localparam int CW       = $clog2(OUT_MW + 3);

    localparam logic signed [IW-1:0] ONE_S      = IW'(1);
    localparam logic signed [IW-1:0] IN_BIAS_S  = IW'(IN_BIAS);
    localparam logic signed [IW-1:0] OUT_BIAS_S = IW'(OUT_BIAS);
    localparam logic signed [IW-1:0] SUB_EXP_IN = IW'(1 - IN_BIAS);
    localparam logic signed [IW-1:0] EMIN_OUT   = IW'(1 - OUT_BIAS);
    localparam logic signed [IW-1:0] EXP_ONES   = IW'((1 << OUT_EW) - 1);
    localparam logic [CW-1:0]        CNT_MAX    = CW'(OUT_MW + 2);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        NORMALISE,
        ROUND,
        PUT_Z
    } state_t;

    typedef enum logic [1:0] {
        CLS_NUM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic                     r_ack;
    logic                     r_stb;
    logic [OUT_EW+OUT_MW:0]   r_z;
    logic [3:0]               r_flags;
    logic [IN_EW+IN_MW:0]     r_a;
    logic [LW-1:0]            r_mant;
    logic signed [IW-1:0]     r_exp;
    logic                     r_sticky;
    logic [CW-1:0]            r_cnt;
    cls_t                     r_cls;

    logic                     w_aSign;
    logic [IN_EW-1:0]         w_aExp;
    logic [IN_MW-1:0]         w_aFrac;
    logic                     w_expZero;
    logic                     w_expOnes;
    logic                     w_fracZero;
    logic                     w_accept;
    logic                     w_denorm;
    logic [OUT_MW-1:0]        w_fracKeep;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_lsb;
    logic                     w_roundUp;
    logic                     w_inexact;
    logic [SW-1:0]            w_sum;
    logic signed [IW-1:0]     w_expOut;
    logic                     w_tiny;
    logic                     w_overflow;
    logic [OUT_EW+OUT_MW:0]   w_resZ;
    logic [3:0]               w_resFlags;

    assign w_aSign    = r_a[IN_EW+IN_MW];
    assign w_aExp     = r_a[IN_EW+IN_MW-1:IN_MW];
    assign w_aFrac    = r_a[IN_MW-1:0];
    assign w_expZero  = (w_aExp == '0);
    assign w_expOnes  = (w_aExp == '1);
    assign w_fracZero = (w_aFrac == '0);
    assign w_accept   = r_ack && input_a_stb;

    // Keep shifting right while the value is below the destination normal
    // range; the shift cap guarantees the loop ends even for huge deficits.
    assign w_denorm = (r_cls == CLS_NUM) && (r_exp < EMIN_OUT) && (r_cnt < CNT_MAX);

    // Rounding view of the working mantissa in destination terms.
    assign w_fracKeep = r_mant[LW-2:LOWW+1];
    assign w_lsb      = r_mant[LOWW+1];
    assign w_guard    = r_mant[LOWW];
    assign w_sticky   = (|r_mant[LOWW-1:0]) | r_sticky;
    assign w_roundUp  = w_guard && (w_sticky || w_lsb);
    assign w_inexact  = w_guard || w_sticky;
    assign w_sum      = {1'b0, r_mant[LW-1], w_fracKeep} + SW'(w_roundUp);
    assign w_tiny     = !w_sum[OUT_MW+1] && !w_sum[OUT_MW];
    assign w_overflow = (w_expOut >= EXP_ONES);

    // Biased destination exponent: a carry out of the mantissa bumps it,
    // a subnormal that rounds up to the hidden bit lands on exponent 1
    // because its working exponent already sits at the normal minimum.
    always_comb begin
        w_expOut = '0;
        if (w_sum[OUT_MW+1]) begin
            w_expOut = r_exp + OUT_BIAS_S + ONE_S;
        end else if (w_sum[OUT_MW]) begin
            w_expOut = r_exp + OUT_BIAS_S;
        end
    end

    // Final packing of the result and its exception flags by operand class.
    always_comb begin
        w_resZ     = '0;
        w_resFlags = '0;
        case (r_cls)
            CLS_ZERO: begin
                w_resZ = {w_aSign, {(OUT_EW+OUT_MW){1'b0}}};
            end
            CLS_INF: begin
                w_resZ = {w_aSign, {OUT_EW{1'b1}}, {OUT_MW{1'b0}}};
            end
            CLS_NAN: begin
                // The source quiet bit is the top stored-fraction bit.
                w_resZ     = {w_aSign, {OUT_EW{1'b1}},
                              w_fracKeep | {1'b1, {(OUT_MW-1){1'b0}}}};
                w_resFlags = {~r_mant[LW-2], 3'b000};
            end
            default: begin
                if (w_overflow) begin
                    w_resZ     = {w_aSign, {OUT_EW{1'b1}}, {OUT_MW{1'b0}}};
                    w_resFlags = 4'b0101;
                end else begin
                    w_resZ     = {w_aSign, w_expOut[OUT_EW-1:0], w_sum[OUT_MW-1:0]};
                    w_resFlags = {2'b00, w_tiny && w_inexact, w_inexact};
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; NORMALISE leaves on the cycle that performs the
    // final shift so each shift costs exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            GET_A: begin
                if (w_accept) begin
                    w_nextState = UNPACK;
                end
            end
            UNPACK: begin
                if (w_expZero && !w_fracZero) begin
                    w_nextState = NORMALISE;
                end else begin
                    w_nextState = ROUND;
                end
            end
            NORMALISE: begin
                if (r_mant[LW-2]) begin
                    w_nextState = ROUND;
                end
            end
            ROUND: begin
                if (!w_denorm) begin
                    w_nextState = PUT_Z;
                end
            end
            PUT_Z: begin
                if (r_stb && output_z_ack) begin
                    w_nextState = GET_A;
                end
            end
            default: begin
                w_nextState = GET_A;
            end
        endcase
    end

    // Handshake registers: ack comes up one cycle after GET_A is entered,
    // stb one cycle after PUT_Z is entered, each drops on its handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack <= 1'b0;
            r_stb <= 1'b0;
        end else begin
            r_ack <= (r_state == GET_A) && !w_accept;
            r_stb <= (r_state == PUT_Z) && !(r_stb && output_z_ack);
        end
    end

    // Datapath: capture, unpack/rebias, normalise, denormalise and pack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_mant   <= '0;
            r_exp    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_cls    <= CLS_ZERO;
            r_z      <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (w_accept) begin
                        r_a <= input_a;
                    end
                end
                UNPACK: begin
                    r_sticky <= 1'b0;
                    r_cnt    <= '0;
                    if (w_expOnes) begin
                        r_cls  <= w_fracZero ? CLS_INF : CLS_NAN;
                        r_mant <= {1'b1, w_aFrac, {PADW{1'b0}}};
                        r_exp  <= '0;
                    end else if (w_expZero) begin
                        r_cls  <= w_fracZero ? CLS_ZERO : CLS_NUM;
                        r_mant <= {1'b0, w_aFrac, {PADW{1'b0}}};
                        r_exp  <= SUB_EXP_IN;
                    end else begin
                        r_cls  <= CLS_NUM;
                        r_mant <= {1'b1, w_aFrac, {PADW{1'b0}}};
                        r_exp  <= $signed({{(IW-IN_EW){1'b0}}, w_aExp}) - IN_BIAS_S;
                    end
                end
                NORMALISE: begin
                    r_mant <= r_mant << 1;
                    r_exp  <= r_exp - ONE_S;
                end
                ROUND: begin
                    if (w_denorm) begin
                        r_mant   <= r_mant >> 1;
                        r_sticky <= r_sticky | r_mant[0];
                        r_exp    <= r_exp + ONE_S;
                        r_cnt    <= r_cnt + CW'(1);
                    end else begin
                        r_z     <= w_resZ;
                        r_flags <= w_resFlags;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign input_a_ack  = r_ack;
    assign output_z_stb = r_stb;
    assign output_z     = r_z;
    assign output_flags = r_flags;

endmodule

// File: tb/tb_float_convert.sv
// tb_float_convert
// Drives two float_convert instances: the default single-to-double widening
// converter (A) and a double-to-single narrowing converter (B). Expected
// results are queued when an operand is issued and compared by a monitor
// whenever a result strobe rises. Latency, output hold under back-pressure
// and asynchronous reset behaviour are checked directly.
module tb_float_convert;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] aIn;
    logic        aInStb;
    logic        aInAck;
    logic [63:0] aZ;
    logic        aZStb;
    logic        aZAck;
    logic [3:0]  aFlags;

    logic [63:0] bIn;
    logic        bInStb;
    logic        bInAck;
    logic [31:0] bZ;
    logic        bZStb;
    logic        bZAck;
    logic [3:0]  bFlags;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] expZA[$];
    logic [3:0]  expFA[$];
    logic [63:0] expZB[$];
    logic [3:0]  expFB[$];

    logic aPrev;
    logic bPrev;

    always #5 clk = ~clk;

    float_convert dutA (
        .clk          (clk),
        .rst          (rst_n),
        .input_a      (aIn),
        .input_a_stb  (aInStb),
        .input_a_ack  (aInAck),
        .output_z     (aZ),
        .output_z_stb (aZStb),
        .output_z_ack (aZAck),
        .output_flags (aFlags)
    );

    float_convert #(
        .IN_EW  (11),
        .IN_MW  (52),
        .OUT_EW (8),
        .OUT_MW (23)
    ) dutB (
        .clk          (clk),
        .rst          (rst_n),
        .input_a      (bIn),
        .input_a_stb  (bInStb),
        .input_a_ack  (bInAck),
        .output_z     (bZ),
        .output_z_stb (bZStb),
        .output_z_ack (bZAck),
        .output_flags (bFlags)
    );

    // One comparison: counts it, reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitors: compare each newly presented result against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            aPrev <= 1'b0;
        end else begin
            if (aZStb && !aPrev) begin
                if (expZA.size() == 0) begin
                    reportTimeout("A unexpected result (no expectation queued)");
                end else begin
                    checkOutput("A result", aZ, expZA.pop_front());
                    checkOutput("A flags", {60'b0, aFlags}, {60'b0, expFA.pop_front()});
                end
            end
            aPrev <= aZStb;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bPrev <= 1'b0;
        end else begin
            if (bZStb && !bPrev) begin
                if (expZB.size() == 0) begin
                    reportTimeout("B unexpected result (no expectation queued)");
                end else begin
                    checkOutput("B result", {32'b0, bZ}, expZB.pop_front());
                    checkOutput("B flags", {60'b0, bFlags}, {60'b0, expFB.pop_front()});
                end
            end
            bPrev <= bZStb;
        end
    end

    // Hands one operand to the selected converter; returns just after the
    // accepting clock edge.
    task automatic sendOperand(input int which, input logic [63:0] val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((which == 0) ? aInAck : bInAck) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            reportTimeout("operand accept");
            return;
        end
        if (which == 0) begin
            aIn    = val[31:0];
            aInStb = 1'b1;
        end else begin
            bIn    = val;
            bInStb = 1'b1;
        end
        @(posedge clk);
        #1;
        aInStb = 1'b0;
        bInStb = 1'b0;
    endtask

    // Queues the expectation, issues the operand and measures how many
    // edges after the accept edge the result strobe rises.
    task automatic applyStimulus(input int which, input logic [63:0] val,
                                 input logic [63:0] expZ, input logic [3:0] expF,
                                 input int expLat, input string name);
        bit ok;
        int lat;
        if (which == 0) begin
            expZA.push_back(expZ);
            expFA.push_back(expF);
        end else begin
            expZB.push_back(expZ);
            expFB.push_back(expF);
        end
        sendOperand(which, val, ok);
        if (!ok) begin
            return;
        end
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0) ? aZStb : bZStb) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            reportTimeout({name, " result strobe"});
        end else begin
            checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
        end
        if ((which == 0) ? aZAck : bZAck) begin
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        rst_n  = 1'b0;
        aIn    = '0;
        aInStb = 1'b0;
        aZAck  = 1'b1;
        bIn    = '0;
        bInStb = 1'b0;
        bZAck  = 1'b1;

        // Reset state and first-cycle ack.
        repeat (2) @(negedge clk);
        checkOutput("reset A ack", {63'b0, aInAck}, 64'd0);
        checkOutput("reset A stb", {63'b0, aZStb}, 64'd0);
        checkOutput("reset B ack", {63'b0, bInAck}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("A ack after reset", {63'b0, aInAck}, 64'd1);
        checkOutput("B ack after reset", {63'b0, bInAck}, 64'd1);

        // Widening single -> double.
        applyStimulus(0, 64'h3F800000, 64'h3FF0000000000000, 4'b0000, 3,  "A one");
        applyStimulus(0, 64'h00000001, 64'h36A0000000000000, 4'b0000, 26, "A min subnormal");
        applyStimulus(0, 64'h7F800001, 64'h7FF8000020000000, 4'b1000, 3,  "A sNaN");
        applyStimulus(0, 64'h7FC00000, 64'h7FF8000000000000, 4'b0000, 3,  "A qNaN");
        applyStimulus(0, 64'hFF800000, 64'hFFF0000000000000, 4'b0000, 3,  "A -inf");
        applyStimulus(0, 64'h80000000, 64'h8000000000000000, 4'b0000, 3,  "A -zero");
        applyStimulus(0, 64'hC0490FDB, 64'hC00921FB60000000, 4'b0000, 3,  "A -pi");
        applyStimulus(0, 64'h00400000, 64'h3800000000000000, 4'b0000, 4,  "A big subnormal");

        // Narrowing double -> single.
        applyStimulus(1, 64'h3FF0000000000000, 64'h3F800000, 4'b0000, 3,  "B one");
        applyStimulus(1, 64'h3FF0000010000000, 64'h3F800000, 4'b0001, 3,  "B tie even");
        applyStimulus(1, 64'h3FF0000030000000, 64'h3F800002, 4'b0001, 3,  "B tie up");
        applyStimulus(1, 64'h3FFFFFFFFFFFFFFF, 64'h40000000, 4'b0001, 3,  "B carry");
        applyStimulus(1, 64'h47F0000000000000, 64'h7F800000, 4'b0101, 3,  "B overflow");
        applyStimulus(1, 64'h47EFFFFFF0000000, 64'h7F800000, 4'b0101, 3,  "B round overflow");
        applyStimulus(1, 64'h3690000000000000, 64'h00000000, 4'b0011, 27, "B 2^-150");
        applyStimulus(1, 64'h36A8000000000000, 64'h00000002, 4'b0011, 26, "B subnormal tie");
        applyStimulus(1, 64'h380FFFFFFFFFFFFF, 64'h00800000, 4'b0001, 4,  "B round to min normal");
        applyStimulus(1, 64'h7FF4000000000000, 64'h7FE00000, 4'b1000, 3,  "B sNaN");
        applyStimulus(1, 64'hFFF0000000000000, 64'hFF800000, 4'b0000, 3,  "B -inf");

        // Back-pressure: result held, no new operand taken.
        aZAck = 1'b0;
        applyStimulus(0, 64'h3F800000, 64'h3FF0000000000000, 4'b0000, 3, "A hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold stb", {63'b0, aZStb}, 64'd1);
            checkOutput("hold z", aZ, 64'h3FF0000000000000);
            checkOutput("hold flags", {60'b0, aFlags}, 64'd0);
            checkOutput("hold input ack", {63'b0, aInAck}, 64'd0);
        end
        aZAck = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stb after ack", {63'b0, aZStb}, 64'd0);
        checkOutput("input ack on stb fall", {63'b0, aInAck}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("input ack following edge", {63'b0, aInAck}, 64'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of NORMALISE.
        sendOperand(0, 64'h00000001, ok);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset A z", aZ, 64'd0);
        checkOutput("mid reset A flags", {60'b0, aFlags}, 64'd0);
        checkOutput("mid reset A stb", {63'b0, aZStb}, 64'd0);
        checkOutput("mid reset A ack", {63'b0, aInAck}, 64'd0);
        checkOutput("mid reset B z", {32'b0, bZ}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("A ack after mid reset", {63'b0, aInAck}, 64'd1);
        applyStimulus(0, 64'h40000000, 64'h4000000000000000, 4'b0000, 3, "A two after reset");

        repeat (5) @(negedge clk);
        checkOutput("A results outstanding", 64'(expZA.size()), 64'd0);
        checkOutput("B results outstanding", 64'(expZB.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
